clap_light_controller: RTL
==========================

// Module: clap_light_controller
// PURPOSE
//  Sequencer at the tail of the clap pipeline, after the sampler, energy and clap-detect stages.
//  Consumes the clap-event stream and recognises a programmed clap pattern: CLAPS_REQUIRED claps, each gap in range.
//  On a match it toggles the light output, then ignores claps for a lockout period.
//  Sole driver of claps_ready and toglite_state at top level.
// PARAMETERS
//  CLAPS_OUT_WIDTH  16          width of clap beat data (samples since previous clap, saturating)
//  CLAPS_REQUIRED   2           claps forming a pattern; legal range 1..15
//  GAP_MIN          40          min accepted inter-clap gap, sample units, inclusive
//  GAP_MAX          2000        max accepted inter-clap gap, sample units, inclusive; GAP_MIN<=GAP_MAX
//  TIMEOUT_CYCLES   50000000    clocks in ARMED without a clap before abandoning the pattern; >=1
//  LOCKOUT_CYCLES   100000000   clocks in LOCKOUT after a toggle; >=1
//  TIMER_WIDTH      27          timer width; must hold max(TIMEOUT_CYCLES, LOCKOUT_CYCLES)
// PORTS
//  clock            in   1                single clock
//  reset            in   1                asynchronous, active-high reset
//  claps_data       in   CLAPS_OUT_WIDTH  gap to previous clap for this beat
//  claps_valid      in   1                clap beat valid
//  claps_ready      out  1                beat accepted when valid&ready at rising edge
//  toglite_state    out  1                light state, toggles per matched pattern
//  toggle_pulse     out  1                one-cycle strobe on the edge toglite_state changes
//  clap_count       out  4                claps counted in the current pattern
//  busy             out  1                1 in ARMED or LOCKOUT
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; timer 0.
//  Reset asserted mid-pattern or mid-lockout aborts immediately and toglite_state returns to 0.
//  claps_ready is registered: 0 in reset, 1 from the first edge after reset deasserts, then held 1.
//   The block never stalls upstream; beats arriving in LOCKOUT are accepted and discarded.
//  gap_ok = (claps_data >= GAP_MIN) && (claps_data <= GAP_MAX), compared unsigned.
//  States:
//   IDLE    beat -> clap_count=1 (data ignored), timer=TIMEOUT_CYCLES-1, go ARMED.
//           If CLAPS_REQUIRED==1, the beat instead causes a match (see MATCH).
//   ARMED   beat & gap_ok -> clap_count+1 and timer reload.
//           If the new count == CLAPS_REQUIRED -> MATCH.
//           beat & !gap_ok -> restart: clap_count=1, timer reload, stay ARMED.
//           No beat & timer==0 -> IDLE, clap_count=0.
//           Otherwise timer decrements.
//   MATCH   Not a state, an action on the accepting edge.
//           toglite_state inverts; toggle_pulse=1 for that cycle only; clap_count=0.
//           timer=LOCKOUT_CYCLES-1; go LOCKOUT.
//   LOCKOUT Timer decrements; beats are dropped.
//           timer==0 -> IDLE on next edge; a beat in that same cycle is still dropped.
//  Latency: beat accepted on edge k -> toglite_state and toggle_pulse change on edge k (1 cycle after valid).
//  Simultaneous: in ARMED, a beat in the timer==0 cycle is processed as a beat; the timeout loses.
//  Timer does not wrap; it holds 0 outside ARMED/LOCKOUT.
//  clap_count saturates at CLAPS_REQUIRED; it never exceeds it.
// STRUCTURE
//  Shared include clap_light_defs.vh holds:
//   state encodings ST_IDLE=2'd0, ST_ARMED=2'd1, ST_LOCKOUT=2'd2.
//   clogb2 function.
//  Sub-module clap_timer: loadable down-counter with load value, load strobe and zero flag.
//   Shared by timeout and lockout.
//  Remainder is one FSM and an output register block.
// TESTING
//  Bench params: CLAPS_REQUIRED=2, GAP 40..2000, TIMEOUT_CYCLES=100, LOCKOUT_CYCLES=50.
//  Reset release -> all outputs 0; claps_ready=1 one cycle later.
//  Beats gap X then 500 -> clap_count 1 then 0; toglite_state 0->1; one toggle_pulse; busy held 50 cycles.
//  Beats gap X then 20 (too short) -> clap_count stays 1, no toggle; then gap 2001 -> still 1, no toggle.
//  One beat, then idle 101 cycles -> IDLE, clap_count 0; next beat gap 500 -> clap_count 1, no toggle.
//  Beat exactly on the timer==0 cycle with gap 40 -> toggle; beat at lockout cycle 49 -> dropped, no toggle.
//  Assert reset mid-ARMED with toglite_state=1 -> toglite_state, clap_count and busy all go 0 asynchronously.

Source files
------------

// File: rtl/clap_light_controller_pkg.sv
// clap_light_controller_pkg: shared state encodings, widths and helpers for the clap sequencer
package clap_light_controller_pkg;
    localparam int COUNT_WIDTH = 4;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;
    function automatic int clogb2(input longint value);
        int r;
        r = 0;
        for (longint v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/clap_light_controller_if.sv
// clap_light_controller_if: valid/ready clap-event stream carrying the gap since the previous clap
interface clap_light_controller_if #(parameter int CLAPS_OUT_WIDTH = 16);
    logic [CLAPS_OUT_WIDTH-1:0] claps_data;
    logic                       claps_valid;
    logic                       claps_ready;
    modport master (output claps_data, claps_valid, input claps_ready);
    modport slave  (input claps_data, claps_valid, output claps_ready);
endinterface

// File: rtl/clap_light_controller_timer.sv
// clap_light_controller_timer: loadable down-counter that stops at zero, shared by timeout and lockout
module clap_light_controller_timer #(
    parameter int TIMER_WIDTH = 27
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic                   zero
);
    logic [TIMER_WIDTH-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_value;
        else if (!zero) cnt <= cnt - TIMER_WIDTH'(1);
    end
endmodule

// File: rtl/clap_light_controller.sv
// clap_light_controller: recognises a timed clap pattern, toggles the light, then locks out further claps
module clap_light_controller
    import clap_light_controller_pkg::*;
#(
    parameter int CLAPS_OUT_WIDTH = 16,
    parameter int CLAPS_REQUIRED  = 2,
    parameter int GAP_MIN         = 40,
    parameter int GAP_MAX         = 2000,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int LOCKOUT_CYCLES  = 100000000,
    parameter int TIMER_WIDTH     = 27
) (
    input  logic                   clock,
    input  logic                   reset,
    clap_light_controller_if.slave claps,
    output logic                   toglite_state,
    output logic                   toggle_pulse,
    output logic [COUNT_WIDTH-1:0] clap_count,
    output logic                   busy
);
    localparam logic [COUNT_WIDTH-1:0] REQ       = COUNT_WIDTH'(CLAPS_REQUIRED);
    localparam logic [TIMER_WIDTH-1:0] T_TIMEOUT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] T_LOCKOUT = TIMER_WIDTH'(LOCKOUT_CYCLES - 1);
    state_t                   state, state_n;
    logic [COUNT_WIDTH-1:0]   count_n, count_inc;
    logic                     tog_n, pulse_n, ready;
    logic                     beat, gap_ok, match, load, zero;
    logic [TIMER_WIDTH-1:0]   load_value;
    assign claps.claps_ready = ready;
    assign beat      = claps.claps_valid && ready;
    assign gap_ok    = (claps.claps_data >= CLAPS_OUT_WIDTH'(GAP_MIN)) &&
                       (claps.claps_data <= CLAPS_OUT_WIDTH'(GAP_MAX));
    assign count_inc = clap_count + COUNT_WIDTH'(1);
    assign busy      = state != ST_IDLE;
    clap_light_controller_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .zero       (zero)
    );
    // A match is an action on the accepting edge, not a state of its own.
    always_comb begin
        match = 1'b0;
        state_n = state;
        count_n = clap_count;
        load = 1'b0;
        load_value = T_TIMEOUT;
        case (state)
            ST_IDLE: begin
                if (beat) begin
                    match = REQ == COUNT_WIDTH'(1);
                    count_n = COUNT_WIDTH'(1);
                    load = 1'b1;
                    state_n = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (beat) begin
                    match = gap_ok && count_inc == REQ;
                    count_n = gap_ok ? count_inc : COUNT_WIDTH'(1);
                    load = 1'b1;
                end else if (zero) begin
                    count_n = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_LOCKOUT: state_n = zero ? ST_IDLE : ST_LOCKOUT;
            default: state_n = ST_IDLE;
        endcase
        if (match) begin
            count_n = '0;
            load_value = T_LOCKOUT;
            state_n = ST_LOCKOUT;
        end
        tog_n = match ? !toglite_state : toglite_state;
        pulse_n = match;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            clap_count <= '0;
            toglite_state <= 1'b0;
            toggle_pulse <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            clap_count <= count_n;
            toglite_state <= tog_n;
            toggle_pulse <= pulse_n;
            ready <= 1'b1;
        end
    end
endmodule
